piso_serializer: RTL and testbench

//   Parallel-in serial-out transmitter: accepts WIDTH-bit words over a valid/ready handshake and

---
 rtl/piso_serializer.sv | 110 +++++++++++
 tb/tb_piso_serializer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: takes WIDTH-bit words over valid/ready and
// shifts them out one bit per clock with frame_start/frame_end strobes.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_o,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, GAPWAIT} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_hold;
  logic             r_holdValid;
  logic [BW-1:0]    r_bitCnt;
  logic [GW-1:0]    r_gapCnt;
  logic             r_serValid;
  logic             r_frameStart;
  logic             r_frameEnd;

  logic             w_xfer;
  logic             w_lastBit;
  logic             w_gapDone;
  logic             w_frameDone;
  logic             w_load;
  logic [WIDTH-1:0] w_loadWord;
  logic [WIDTH-1:0] w_shifted;

  assign in_ready    = !r_holdValid && !rst;
  assign w_xfer      = in_valid && in_ready;
  assign w_lastBit   = (r_state == SHIFT) && (r_bitCnt == BW'(WIDTH - 1));
  assign w_gapDone   = (r_state == GAPWAIT) && (r_gapCnt == GW'(1));
  // A frame is "done" when the next word may start on this edge.
  assign w_frameDone = (w_lastBit && (GAP == 0)) || w_gapDone;
  assign w_load      = ((r_state == IDLE) && w_xfer) ||
                       (w_frameDone && (r_holdValid || w_xfer));
  assign w_loadWord  = r_holdValid ? r_hold : in_data;
  assign w_shifted   = LSB_FIRST ? {1'b0, r_shift[WIDTH-1:1]}
                                 : {r_shift[WIDTH-2:0], 1'b0};

  // Zeros shift in behind the frame, so ser_o is already 0 once a frame ends.
  assign ser_o       = LSB_FIRST ? r_shift[0] : r_shift[WIDTH-1];
  assign ser_valid   = r_serValid;
  assign frame_start = r_frameStart;
  assign frame_end   = r_frameEnd;
  assign busy        = (r_state != IDLE) || r_holdValid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_hold       <= '0;
      r_holdValid  <= 1'b0;
      r_bitCnt     <= '0;
      r_gapCnt     <= '0;
      r_serValid   <= 1'b0;
      r_frameStart <= 1'b0;
      r_frameEnd   <= 1'b0;
    end else begin
      if (w_load && r_holdValid) begin
        r_holdValid <= 1'b0;
      end else if (w_xfer && !w_load) begin
        r_hold      <= in_data;
        r_holdValid <= 1'b1;
      end

      if (w_load) begin
        r_state      <= SHIFT;
        r_shift      <= w_loadWord;
        r_bitCnt     <= '0;
        r_serValid   <= 1'b1;
        r_frameStart <= 1'b1;
        r_frameEnd   <= 1'b0;
      end else if (w_lastBit && (GAP > 0)) begin
        r_state    <= GAPWAIT;
        r_gapCnt   <= GW'(GAP);
        r_shift    <= w_shifted;
        r_serValid <= 1'b0;
        r_frameEnd <= 1'b0;
      end else if (w_frameDone) begin
        r_state    <= IDLE;
        r_shift    <= '0;
        r_serValid <= 1'b0;
        r_frameEnd <= 1'b0;
      end else if (r_state == SHIFT) begin
        r_shift      <= w_shifted;
        r_bitCnt     <= r_bitCnt + 1'b1;
        r_frameStart <= 1'b0;
        r_frameEnd   <= (r_bitCnt == BW'(WIDTH - 2));
      end else if (r_state == GAPWAIT) begin
        r_gapCnt <= r_gapCnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three instances (MSB-first, LSB-first, GAP=2) against a
// frame-timeline model, plus literal checks on captured serial traces.
module tb_piso_serializer;

  typedef logic [7:0] wlist_t [8];

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       inValid [3];
  logic [7:0] inData  [3];
  logic       so [3], sv [3], fs [3], fe [3], bz [3], rdy [3];

  int nChecks = 0;
  int nPass   = 0;
  int ec      = 0;
  bit checking = 1'b0;

  // Model: every accepted word with its accept edge and the cycle its first bit appears.
  logic [7:0] frW   [3][64];
  int         frSt  [3][64];
  int         frAcc [3][64];
  int         nFr   [3];

  logic logO [3][4096];
  logic logV [3][4096];
  logic logS [3][4096];
  logic logE [3][4096];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .GAP(0)) dutMsb (
    .clk(clk), .rst(rst), .in_data(inData[0]), .in_valid(inValid[0]), .in_ready(rdy[0]),
    .ser_o(so[0]), .ser_valid(sv[0]), .frame_start(fs[0]), .frame_end(fe[0]), .busy(bz[0]));

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .GAP(0)) dutLsb (
    .clk(clk), .rst(rst), .in_data(inData[1]), .in_valid(inValid[1]), .in_ready(rdy[1]),
    .ser_o(so[1]), .ser_valid(sv[1]), .frame_start(fs[1]), .frame_end(fe[1]), .busy(bz[1]));

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .GAP(2)) dutGap (
    .clk(clk), .rst(rst), .in_data(inData[2]), .in_valid(inValid[2]), .in_ready(rdy[2]),
    .ser_o(so[2]), .ser_valid(sv[2]), .frame_start(fs[2]), .frame_end(fe[2]), .busy(bz[2]));

  function automatic int gapOf(input int k);
    return (k == 2) ? 2 : 0;
  endfunction

  // A word sits in the hold buffer from its accept cycle until the cycle before its first bit.
  function automatic bit holdAt(input int k, input int c);
    bit h = 1'b0;
    for (int j = 0; j < nFr[k]; j++)
      if (frAcc[k][j] <= c && frSt[k][j] > c) h = 1'b1;
    return h;
  endfunction

  function automatic logic [5:0] expVec(input int k, input int c);
    logic eo = 1'b0, ev = 1'b0, es = 1'b0, ee = 1'b0, eb = 1'b0;
    bit   h;
    for (int j = 0; j < nFr[k]; j++) begin
      int i;
      i = c - frSt[k][j];
      if (i >= 0 && i < 8) begin
        ev = 1'b1;
        eb = 1'b1;
        eo = (k == 1) ? frW[k][j][i] : frW[k][j][7 - i];
        es = (i == 0);
        ee = (i == 7);
      end
      if (i >= 8 && i < 8 + gapOf(k)) eb = 1'b1;
    end
    h = holdAt(k, c);
    if (h) eb = 1'b1;
    return {!h, eb, es, ee, ev, eo};
  endfunction

  always @(posedge clk) begin
    ec = ec + 1;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        nFr[k] = 0;
      end else if (inValid[k] && !holdAt(k, ec - 1) && nFr[k] < 64) begin
        int st;
        st = ec;
        if (nFr[k] > 0 && frSt[k][nFr[k] - 1] + 8 + gapOf(k) > st)
          st = frSt[k][nFr[k] - 1] + 8 + gapOf(k);
        frAcc[k][nFr[k]] = ec;
        frSt[k][nFr[k]]  = st;
        frW[k][nFr[k]]   = inData[k];
        nFr[k] = nFr[k] + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, ec);
  endtask

  task automatic compareLoop();
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (ec < 4096) begin
          logO[k][ec] = so[k];
          logV[k][ec] = sv[k];
          logS[k][ec] = fs[k];
          logE[k][ec] = fe[k];
        end
        if (checking) begin
          logic [5:0] act, exp;
          act = {rst ? 1'b0 : rdy[k], bz[k], fs[k], fe[k], sv[k], so[k]};
          exp = rst ? 6'b0 : expVec(k, ec);
          checkOutput($sformatf("cycle dut%0d {rdy,busy,fs,fe,sv,so}", k), 32'(act), 32'(exp));
        end
      end
    end
  endtask

  function automatic int firstValid(input int k, input int from);
    for (int c = from; c <= ec && c < 4096; c++)
      if (logV[k][c] === 1'b1) return c;
    return -1;
  endfunction

  // Packs n logged cycles starting at 'from'; the earliest cycle lands in the MSB.
  function automatic logic [31:0] packLog(input int k, input int from, input int n, input int sel);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) begin
      logic b;
      int   c;
      c = from + i;
      b = 1'b0;
      if (c >= 0 && c < 4096) begin
        case (sel)
          0:       b = logO[k][c];
          1:       b = logV[k][c];
          2:       b = logS[k][c];
          default: b = logE[k][c];
        endcase
      end
      r = {r[30:0], b};
    end
    return r;
  endfunction

  task automatic sendBurst(input int k, input wlist_t words, input int n);
    int guard;
    @(negedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      inValid[k] = 1'b1;
      inData[k]  = words[i];
      guard = 0;
      while (rdy[k] !== 1'b1 && guard < 200) begin
        @(posedge clk);
        #1;
        guard++;
      end
      if (guard >= 200) checkOutput($sformatf("ready timeout dut%0d", k), 32'd0, 32'd1);
      @(posedge clk);
      #1;
    end
    inValid[k] = 1'b0;
  endtask

  task automatic applyStimulus(input wlist_t w, input int n);
    fork
      sendBurst(0, w, n);
      sendBurst(1, w, n);
      sendBurst(2, w, n);
    join
  endtask

  initial begin
    wlist_t w;
    int     mark, f;
    for (int k = 0; k < 3; k++) begin
      inValid[k] = 1'b0;
      inData[k]  = 8'h00;
      nFr[k]     = 0;
    end
    fork
      compareLoop();
    join_none

    // Asynchronous reset pulse in mid-period.
    @(posedge clk);
    #3 rst = 1'b1;
    #1 checkOutput("reset outputs immediate",
                   32'({sv[0], so[0], fs[0], fe[0], bz[0], sv[1], so[1], fs[1], fe[1], bz[1],
                        sv[2], so[2], fs[2], fe[2], bz[2]}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    checking = 1'b1;
    #1 checkOutput("ready after reset", 32'({rdy[0], rdy[1], rdy[2]}), 32'b111);
    checkOutput("busy after reset", 32'({bz[0], bz[1], bz[2]}), 32'b000);
    repeat (3) @(posedge clk);

    // Single word.
    mark = ec;
    w = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    applyStimulus(w, 1);
    repeat (14) @(posedge clk);
    #1;
    f = firstValid(0, mark + 1);
    checkOutput("A5 bits msb-first", packLog(0, f, 8, 0), 32'hA5);
    checkOutput("A5 valid then idle", packLog(0, f, 9, 1), 32'h1FE);
    checkOutput("A5 frame_start", packLog(0, f, 8, 2), 32'h80);
    checkOutput("A5 frame_end", packLog(0, f, 8, 3), 32'h01);
    checkOutput("A5 ser_o after frame", packLog(0, f + 8, 1, 0), 32'h0);

    // Back-to-back words through the hold buffer.
    mark = ec;
    w = '{8'hA5, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    applyStimulus(w, 2);
    repeat (26) @(posedge clk);
    #1;
    f = firstValid(0, mark + 1);
    checkOutput("A5,3C bits", packLog(0, f, 16, 0), 32'hA53C);
    checkOutput("A5,3C contiguous valid", packLog(0, f, 17, 1), 32'h1FFFE);
    checkOutput("A5,3C frame_start", packLog(0, f, 16, 2), 32'h8080);
    checkOutput("A5,3C frame_end", packLog(0, f, 16, 3), 32'h0101);

    // LSB-first ordering.
    mark = ec;
    w = '{8'h01, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    applyStimulus(w, 2);
    repeat (26) @(posedge clk);
    #1;
    f = firstValid(1, mark + 1);
    checkOutput("lsb 01,80 bits", packLog(1, f, 16, 0), 32'h8001);
    f = firstValid(0, mark + 1);
    checkOutput("msb 01,80 bits", packLog(0, f, 16, 0), 32'h0180);

    // Forced gap of two idle cycles.
    mark = ec;
    w = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    applyStimulus(w, 2);
    repeat (28) @(posedge clk);
    #1;
    f = firstValid(2, mark + 1);
    checkOutput("gap FF,00 valid", packLog(2, f, 18, 1), 32'h3FCFF);
    checkOutput("gap FF,00 bits", packLog(2, f, 18, 0), 32'h3FC00);

    // Reset during bit 4 of an in-flight frame.
    w = '{8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    sendBurst(0, w, 1);
    repeat (3) @(posedge clk);
    #3 checkOutput("F0 bit4 before reset", 32'({sv[0], so[0]}), 32'b11);
    rst = 1'b1;
    #1 checkOutput("mid-frame reset outputs", 32'({sv[0], so[0], fs[0], fe[0], bz[0]}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    #1 checkOutput("ready after mid reset", 32'(rdy[0]), 32'd1);
    mark = ec;
    w = '{8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    sendBurst(0, w, 1);
    repeat (14) @(posedge clk);
    #1;
    f = firstValid(0, mark + 1);
    checkOutput("81 after reset bits", packLog(0, f, 8, 0), 32'h81);
    checkOutput("81 after reset valid", packLog(0, f, 9, 1), 32'h1FE);

    // Longer stream with stalls while the hold buffer is full.
    for (int i = 0; i < 8; i++) w[i] = 8'($urandom);
    applyStimulus(w, 8);
    repeat (40) @(posedge clk);
    #1;

    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
